// File: rtl/spi_controller.sv
// spi_controller: quad-lane SPI initiator for single-word register access.
//
// Accepts one read or write request on a valid/ready port and turns it into
// one CS_N-framed mode-0 transfer. Each SCK cycle carries one nibble, MSB
// nibble first:
//   CMD (2 nibbles)  {we, zero pad, wmask}; reads send a zero mask
//   ADDR             AWIDTH/4 nibbles
//   write: DATA      DWIDTH/4 nibbles driven on COPI
//   read:  DUMMY turnaround cycles, then DWIDTH/4 nibbles sampled from CIPO
// Every completed transfer ends with a one-cycle rsp_valid pulse. rsp_rdata
// is updated only by reads.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   req_we, req_addr, req_wdata, req_wmask   request fields
//   rsp_valid, rsp_rdata   completion strobe and read data
//   busy                   transfer in progress
//   CS_N, SCK, COPI, CIPO  SPI bus (SCK idles low)
//
// Build option: define SPI_CTRL_CIPO_SYNC_EN to route CIPO through a 2-flop
// synchroniser. Capture then happens two clk cycles after each SCK-rise tick,
// which needs CLK_DIV >= 3. Frame and response timing are unchanged.
module spi_controller #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int MWIDTH  = DWIDTH / 8,
    parameter int CLK_DIV = 2,
    parameter int DUMMY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [MWIDTH-1:0] req_wmask,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              busy,
    output logic              CS_N,
    output logic              SCK,
    output logic [3:0]        COPI,
    input  logic [3:0]        CIPO
);

    localparam int N_WR     = 2 + AWIDTH / 4 + DWIDTH / 4;
    localparam int N_RD     = 2 + AWIDTH / 4 + DUMMY + DWIDTH / 4;
    localparam int RD_FIRST = 2 + AWIDTH / 4 + DUMMY;   // first SCK cycle carrying read data
    localparam int FW       = 8 + AWIDTH + DWIDTH;
    localparam int NMAX     = (N_RD > N_WR) ? N_RD : N_WR;
    localparam int CW       = $clog2(NMAX + 1);
    localparam int DIVW     = $clog2(CLK_DIV);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    if (CLK_DIV < 2) begin : g_chk_div
        $error("spi_controller: CLK_DIV must be at least 2");
    end
    if (MWIDTH > 7) begin : g_chk_mask
        $error("spi_controller: MWIDTH must be at most 7");
    end

    logic [2:0]        state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [CW-1:0]     nib_q, nib_d;
    logic              ph_q, ph_d;
    logic              we_q, we_d;
    logic              csn_q, csn_d;
    logic              sck_q, sck_d;
    logic [3:0]        copi_q, copi_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [FW-1:0]     sr_q, sr_d;
    logic [DWIDTH-1:0] rd_sr_q;
    logic              tick, cap_now, cap_en;
    logic [3:0]        cap_nib;
    logic [6:0]        mask7;
    logic [FW-1:0]     frame;
    logic [CW-1:0]     n_last;

    // Reads carry a zero mask and zero data so COPI stays low after ADDR.
    assign mask7  = req_we ? 7'(req_wmask) : 7'd0;
    assign frame  = {req_we, mask7, req_addr, req_we ? req_wdata : {DWIDTH{1'b0}}};
    assign n_last = we_q ? CW'(N_WR - 1) : CW'(N_RD - 1);
    assign tick   = (div_q == DIVW'(CLK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        nib_d       = nib_q;
        ph_d        = ph_q;
        we_d        = we_q;
        csn_d       = csn_q;
        sck_d       = sck_q;
        copi_d      = copi_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        sr_d        = sr_q;
        cap_now     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    csn_d   = 1'b0;
                    we_d    = req_we;
                    nib_d   = '0;
                    copi_d  = frame[FW-1 -: 4];
                    sr_d    = frame << 4;
                end
            end
            SETUP: begin
                // The first rise is CMD nibble 0, never read data.
                if (tick) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        sck_d  = 1'b0;
                        copi_d = sr_q[FW-1 -: 4];
                        sr_d   = sr_q << 4;
                    end else if (nib_q == n_last) begin
                        state_d = HOLD;
                    end else begin
                        sck_d   = 1'b1;
                        nib_d   = nib_q + 1'b1;
                        // nib_q + 1 is the index of the SCK cycle now rising.
                        cap_now = !we_q && (nib_q >= CW'(RD_FIRST - 1));
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d     = GAP;
                    csn_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    ph_d        = 1'b0;
                    if (!we_q) begin
                        rdata_d = rd_sr_q;
                    end
                end
            end
            GAP: begin
                // Two half-periods with CS_N high before the next request.
                if (tick) begin
                    if (ph_q) begin
                        state_d = IDLE;
                    end else begin
                        ph_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                csn_d   = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            nib_q       <= '0;
            ph_q        <= 1'b0;
            we_q        <= 1'b0;
            csn_q       <= 1'b1;
            sck_q       <= 1'b0;
            copi_q      <= 4'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            nib_q       <= nib_d;
            ph_q        <= ph_d;
            we_q        <= we_d;
            csn_q       <= csn_d;
            sck_q       <= sck_d;
            copi_q      <= copi_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef SPI_CTRL_CIPO_SYNC_EN
    if (CLK_DIV < 3) begin : g_chk_sync
        $error("spi_controller: SPI_CTRL_CIPO_SYNC_EN requires CLK_DIV >= 3");
    end

    logic [3:0] cipo_s1_q, cipo_s2_q;
    logic       cap1_q, cap2_q;

    always_ff @(posedge clk) begin
        cipo_s1_q <= CIPO;
        cipo_s2_q <= cipo_s1_q;
    end

    // The capture strobe is delayed by the same two cycles as the data, so
    // the nibble present at the SCK-rise tick is the one captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap1_q <= 1'b0;
            cap2_q <= 1'b0;
        end else begin
            cap1_q <= cap_now;
            cap2_q <= cap1_q;
        end
    end

    assign cap_en  = cap2_q;
    assign cap_nib = cipo_s2_q;
`else
    assign cap_en  = cap_now;
    assign cap_nib = CIPO;
`endif

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            rd_sr_q <= (rd_sr_q << 4) | DWIDTH'(cap_nib);
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign CS_N      = csn_q;
    assign SCK       = sck_q;
    assign COPI      = copi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule
